// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding, hazard detection and MDU scoreboard for a 5-stage pipeline
module fwd_hazard_unit #(
    parameter int NPORT = 2,
    parameter int RA_W  = 5,
    parameter int LAT_W = 6,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NPORT*RA_W-1:0]   srcD,
    input  logic [NPORT-1:0]        useD,
    input  logic [NPORT*RA_W-1:0]   srcE,
    input  logic [RA_W-1:0]         WAE,
    input  logic [RA_W-1:0]         WAM,
    input  logic [RA_W-1:0]         WAW,
    input  logic                    wregE,
    input  logic                    wregM,
    input  logic                    wregW,
    input  logic                    memrdE,
    input  logic                    memrdM,
    input  logic                    mdu_startE,
    input  logic [LAT_W-1:0]        mdu_latE,
    input  logic [RA_W-1:0]         mdu_dstE,
    input  logic                    clr_cnt,
    output logic [NPORT-1:0]        forwardD,
    output logic [2*NPORT-1:0]      forwardE,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    stallE,
    output logic                    flushE,
    output logic                    flushM,
    output logic                    mdu_busy,
    output logic                    mdu_wb,
    output logic [CNT_W-1:0]        stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [RA_W-1:0]    mdu_dst_q, mdu_dst_d;
    logic               pending_q, pending_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               ld_haz, br_haz, sb_haz, dstall, sstall;

    assign mdu_busy  = (state_q != S_IDLE);
    assign mdu_wb    = (state_q == S_DONE);
    assign stall_cnt = stall_cnt_q;

    // A new op may be accepted from IDLE or in the writeback cycle of the previous one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_dst_d = mdu_dst_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                if (mdu_startE) begin
                    state_d   = S_BUSY;
                    cnt_d     = (mdu_latE == '0) ? LAT_W'(1) : mdu_latE;
                    mdu_dst_d = mdu_dstE;
                    pending_d = 1'b1;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q <= LAT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                pending_d = 1'b0;
                if (mdu_startE) begin
                    state_d   = S_BUSY;
                    cnt_d     = (mdu_latE == '0) ? LAT_W'(1) : mdu_latE;
                    mdu_dst_d = mdu_dstE;
                    pending_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ld_haz   = 1'b0;
        br_haz   = 1'b0;
        sb_haz   = 1'b0;
        forwardD = '0;
        forwardE = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (srcD[p*RA_W +: RA_W] != '0) begin
                if (wregM && !memrdM && (srcD[p*RA_W +: RA_W] == WAM)) begin
                    forwardD[p] = 1'b1;
                end
                if (memrdE && wregE && (srcD[p*RA_W +: RA_W] == WAE)) begin
                    ld_haz = 1'b1;
                end
                if (useD[p] && (((srcD[p*RA_W +: RA_W] == WAE) && wregE) ||
                                ((srcD[p*RA_W +: RA_W] == WAM) && memrdM))) begin
                    br_haz = 1'b1;
                end
                if (pending_q && !mdu_wb && (srcD[p*RA_W +: RA_W] == mdu_dst_q)) begin
                    sb_haz = 1'b1;
                end
            end
            if (srcE[p*RA_W +: RA_W] != '0) begin
                if (mdu_wb && (srcE[p*RA_W +: RA_W] == mdu_dst_q)) begin
                    forwardE[2*p +: 2] = 2'b11;
                end else if (wregM && !memrdM && (srcE[p*RA_W +: RA_W] == WAM)) begin
                    forwardE[2*p +: 2] = 2'b01;
                end else if (wregW && (srcE[p*RA_W +: RA_W] == WAW)) begin
                    forwardE[2*p +: 2] = 2'b10;
                end
            end
        end
    end

    // A structural stall holds E as well, so E must not be flushed under it.
    always_comb begin
        dstall = ld_haz | br_haz | sb_haz;
        sstall = mdu_startE && (state_q == S_BUSY);
        stallF = dstall | sstall;
        stallD = dstall | sstall;
        stallE = sstall;
        flushE = dstall & ~sstall;
        flushM = sstall;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
        end else if (stallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mdu_dst_q   <= '0;
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mdu_dst_q   <= mdu_dst_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    localparam int NPORT = 2;
    localparam int RA_W  = 5;
    localparam int LAT_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  resetn;
    logic [NPORT*RA_W-1:0] srcD, srcE;
    logic [NPORT-1:0]      useD;
    logic [RA_W-1:0]       WAE, WAM, WAW, mdu_dstE;
    logic                  wregE, wregM, wregW, memrdE, memrdM, mdu_startE, clr_cnt;
    logic [LAT_W-1:0]      mdu_latE;

    logic [NPORT-1:0]      forwardD, forwardD_s;
    logic [2*NPORT-1:0]    forwardE, forwardE_s;
    logic                  stallF, stallD, stallE, flushE, flushM, mdu_busy, mdu_wb;
    logic                  stallF_s, stallD_s, stallE_s, flushE_s, flushM_s, mdu_busy_s, mdu_wb_s;
    logic [31:0]           stall_cnt;
    logic [2:0]            stall_cnt_s;

    fwd_hazard_unit dut (
        .clk(clk), .resetn(resetn), .srcD(srcD), .useD(useD), .srcE(srcE),
        .WAE(WAE), .WAM(WAM), .WAW(WAW), .wregE(wregE), .wregM(wregM), .wregW(wregW),
        .memrdE(memrdE), .memrdM(memrdM), .mdu_startE(mdu_startE), .mdu_latE(mdu_latE),
        .mdu_dstE(mdu_dstE), .clr_cnt(clr_cnt), .forwardD(forwardD), .forwardE(forwardE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE), .flushM(flushM),
        .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.CNT_W(3)) dut_s (
        .clk(clk), .resetn(resetn), .srcD(srcD), .useD(useD), .srcE(srcE),
        .WAE(WAE), .WAM(WAM), .WAW(WAW), .wregE(wregE), .wregM(wregM), .wregW(wregW),
        .memrdE(memrdE), .memrdM(memrdM), .mdu_startE(mdu_startE), .mdu_latE(mdu_latE),
        .mdu_dstE(mdu_dstE), .clr_cnt(clr_cnt), .forwardD(forwardD_s), .forwardE(forwardE_s),
        .stallF(stallF_s), .stallD(stallD_s), .stallE(stallE_s), .flushE(flushE_s), .flushM(flushM_s),
        .mdu_busy(mdu_busy_s), .mdu_wb(mdu_wb_s), .stall_cnt(stall_cnt_s)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: the MDU is described by the absolute cycle of its writeback.
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_wb_cyc = 0;
    logic [4:0]  m_dst = '0;
    longint      m_cnt = 0;
    int          m_cnt3 = 0;
    bit          e_stallD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] sd(input int p);
        return srcD[p*RA_W +: RA_W];
    endfunction

    function automatic logic [4:0] se(input int p);
        return srcE[p*RA_W +: RA_W];
    endfunction

    task automatic model_check();
        bit wb, pend, ld, br, sb, dst, sst;
        logic [NPORT-1:0]   fd;
        logic [2*NPORT-1:0] fe;
        wb   = m_active && (cyc == m_wb_cyc);
        pend = m_active && (cyc < m_wb_cyc);
        ld = 0; br = 0; sb = 0; fd = '0; fe = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (sd(p) != 0) begin
                fd[p] = wregM && !memrdM && sd(p) == WAM;
                if (memrdE && wregE && sd(p) == WAE) ld = 1;
                if (useD[p] && ((wregE && sd(p) == WAE) || (memrdM && sd(p) == WAM))) br = 1;
                if (pend && !wb && sd(p) == m_dst) sb = 1;
            end
            if (se(p) == 0)                              fe[2*p +: 2] = 2'd0;
            else if (wb && se(p) == m_dst)               fe[2*p +: 2] = 2'd3;
            else if (wregM && !memrdM && se(p) == WAM)   fe[2*p +: 2] = 2'd1;
            else if (wregW && se(p) == WAW)              fe[2*p +: 2] = 2'd2;
        end
        dst = ld || br || sb;
        sst = mdu_startE && m_active && !wb;
        e_stallD = dst || sst;
        if (chk_en) begin
            chk("m_forwardD", 32'(forwardD), 32'(fd));
            chk("m_forwardE", 32'(forwardE), 32'(fe));
            chk("m_stallF",   32'(stallF),   32'(dst || sst));
            chk("m_stallD",   32'(stallD),   32'(dst || sst));
            chk("m_stallE",   32'(stallE),   32'(sst));
            chk("m_flushE",   32'(flushE),   32'(dst && !sst));
            chk("m_flushM",   32'(flushM),   32'(sst));
            chk("m_busy",     32'(mdu_busy), 32'(m_active));
            chk("m_wb",       32'(mdu_wb),   32'(wb));
            chk("m_cnt",      stall_cnt,     32'(m_cnt));
            chk("m_cnt3",     32'(stall_cnt_s), 32'(m_cnt3));
        end
    endtask

    task automatic model_update();
        bit wb;
        int lat;
        wb  = m_active && (cyc == m_wb_cyc);
        lat = (mdu_latE == 0) ? 1 : int'(mdu_latE);
        if (!resetn) begin
            m_active = 0; m_cnt = 0; m_cnt3 = 0;
        end else begin
            if (mdu_startE && (!m_active || wb)) begin
                m_active = 1; m_wb_cyc = cyc + lat + 1; m_dst = mdu_dstE;
            end else if (wb) begin
                m_active = 0;
            end
            if (clr_cnt) begin
                m_cnt = 0; m_cnt3 = 0;
            end else if (e_stallD) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt3 < 7) m_cnt3++;
            end
        end
        cyc++;
    endtask

    task automatic step();
        model_check();
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        resetn = 1; srcD = '0; srcE = '0; useD = '0; WAE = '0; WAM = '0; WAW = '0;
        wregE = 0; wregM = 0; wregW = 0; memrdE = 0; memrdM = 0;
        mdu_startE = 0; mdu_latE = '0; mdu_dstE = '0; clr_cnt = 0;
    endtask

    task automatic load_use();
        memrdE = 1; wregE = 1; WAE = 5'd8; srcD = {5'd8, 5'd0};
    endtask

    initial begin
        clear_inputs();
        resetn = 0;
        @(negedge clk); #1;
        step();
        chk_en = 1;
        resetn = 0; #1; step();

        // reset state
        clear_inputs(); #1;
        chk("rst_busy", 32'(mdu_busy), 32'd0);
        chk("rst_wb", 32'(mdu_wb), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_stallF", 32'(stallF), 32'd0);
        step();

        // forwardE priority
        srcE = {5'd0, 5'd5}; WAM = 5'd5; wregM = 1; WAW = 5'd5; wregW = 1; #1;
        chk("prio_M", 32'(forwardE[1:0]), 32'd1);
        step();
        wregM = 0; #1;
        chk("prio_W", 32'(forwardE[1:0]), 32'd2);
        step();
        srcE = '0; #1;
        chk("prio_zero", 32'(forwardE[1:0]), 32'd0);
        step();

        // load-use
        clear_inputs(); load_use(); #1;
        chk("lu_stallF", 32'(stallF), 32'd1);
        chk("lu_stallD", 32'(stallD), 32'd1);
        chk("lu_flushE", 32'(flushE), 32'd1);
        chk("lu_cnt0", stall_cnt, 32'd0);
        step();
        clear_inputs(); #1;
        chk("lu_release", 32'(stallD), 32'd0);
        chk("lu_cnt1", stall_cnt, 32'd1);
        step();

        // MDU latency, scoreboard and back-to-back
        mdu_startE = 1; mdu_latE = 6'd3; mdu_dstE = 5'd9; #1;
        chk("mdu_t0_busy", 32'(mdu_busy), 32'd0);
        step();
        clear_inputs(); srcD = {5'd0, 5'd9}; #1;
        chk("mdu_t1_busy", 32'(mdu_busy), 32'd1);
        chk("mdu_t1_sb", 32'(stallD), 32'd1);
        chk("mdu_t1_wb", 32'(mdu_wb), 32'd0);
        step();
        mdu_startE = 1; mdu_latE = 6'd2; mdu_dstE = 5'd12; #1;
        chk("b2b_t2_stallE", 32'(stallE), 32'd1);
        chk("b2b_t2_flushM", 32'(flushM), 32'd1);
        chk("b2b_t2_flushE", 32'(flushE), 32'd0);
        chk("b2b_t2_stallD", 32'(stallD), 32'd1);
        step();
        #1;
        chk("b2b_t3_stallE", 32'(stallE), 32'd1);
        chk("b2b_t3_flushM", 32'(flushM), 32'd1);
        step();
        srcE = {5'd0, 5'd9}; #1;
        chk("mdu_t4_wb", 32'(mdu_wb), 32'd1);
        chk("mdu_t4_fwdE", 32'(forwardE[1:0]), 32'd3);
        chk("b2b_t4_stallE", 32'(stallE), 32'd0);
        chk("b2b_t4_flushM", 32'(flushM), 32'd0);
        chk("mdu_t4_stallD", 32'(stallD), 32'd0);
        step();
        clear_inputs(); #1;
        chk("b2b_t5_busy", 32'(mdu_busy), 32'd1);
        chk("b2b_t5_wb", 32'(mdu_wb), 32'd0);
        step();
        #1; step();
        #1;
        chk("b2b_t7_wb", 32'(mdu_wb), 32'd1);
        step();
        #1; step();

        // reset mid-operation
        mdu_startE = 1; mdu_latE = 6'd3; mdu_dstE = 5'd9; #1; step();
        clear_inputs(); #1; step();
        resetn = 0; #1;
        chk("rmid_busy_pre", 32'(mdu_busy), 32'd1);
        step();
        resetn = 1; #1;
        chk("rmid_busy", 32'(mdu_busy), 32'd0);
        chk("rmid_wb3", 32'(mdu_wb), 32'd0);
        step();
        #1;
        chk("rmid_wb4", 32'(mdu_wb), 32'd0);
        step();

        // saturation with CNT_W=3
        clr_cnt = 1; #1; step();
        clear_inputs(); load_use();
        for (int i = 0; i < 10; i++) begin
            #1; step();
        end
        #1;
        chk("sat_cnt3", 32'(stall_cnt_s), 32'd7);
        chk("sat_cnt32", stall_cnt, 32'd10);
        clr_cnt = 1; #1; step();
        clear_inputs(); #1;
        chk("clr_cnt3", 32'(stall_cnt_s), 32'd0);
        chk("clr_cnt32", stall_cnt, 32'd0);
        step();

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            resetn     = ($urandom_range(0, 59) != 0);
            for (int p = 0; p < NPORT; p++) begin
                srcD[p*RA_W +: RA_W] = 5'($urandom_range(0, 4));
                srcE[p*RA_W +: RA_W] = 5'($urandom_range(0, 4));
            end
            useD       = 2'($urandom_range(0, 3));
            WAE        = 5'($urandom_range(0, 4));
            WAM        = 5'($urandom_range(0, 4));
            WAW        = 5'($urandom_range(0, 4));
            wregE      = 1'($urandom_range(0, 1));
            wregM      = 1'($urandom_range(0, 1));
            wregW      = 1'($urandom_range(0, 1));
            memrdE     = ($urandom_range(0, 3) == 0);
            memrdM     = ($urandom_range(0, 3) == 0);
            mdu_startE = ($urandom_range(0, 3) == 0);
            mdu_latE   = 6'($urandom_range(0, 5));
            mdu_dstE   = 5'($urandom_range(0, 4));
            clr_cnt    = ($urandom_range(0, 29) == 0);
            #1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL provide parameter NPORT, default 2: number of source-register ports per stage, with port 0 = rs and port 1 = rt.
REQ-002 SHALL provide parameter RA_W, default 5: register-address width.
REQ-003 SHALL provide parameter LAT_W, default 6: width of the multi-cycle unit (MDU) latency counter.
REQ-004 SHALL provide parameter CNT_W, default 32: stall-counter width.
REQ-005 SHALL provide the following ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge
- resetn  in  1  synchronous, active-low reset
- srcD  in  NPORT*RA_W  source addresses in D; port p at [p*RA_W +: RA_W]
- useD  in  NPORT  per-port "source read in D" (branch compare)
- srcE  in  NPORT*RA_W  source addresses in E
- WAE, WAM, WAW  in  RA_W each  destination address in E/M/W
- wregE, wregM, wregW  in  1 each  destination-write enable in E/M/W
- memrdE, memrdM  in  1 each  load in E/M
- mdu_startE  in  1  MDU op in E
- mdu_latE  in  LAT_W  MDU latency in cycles
- mdu_dstE  in  RA_W  MDU result register
- clr_cnt  in  1  clear stall counter
- forwardD  out  NPORT  per port: 1 = take M result
- forwardE  out  2*NPORT  per port: 00 = register file, 01 = M, 10 = W, 11 = MDU result
- stallF, stallD, stallE  out  1 each  hold stage register
- flushE, flushM  out  1 each  insert bubble
- mdu_busy  out  1  MDU state is not IDLE
- mdu_wb  out  1  MDU writes mdu_dst this cycle
- stall_cnt  out  CNT_W  cycles with stallD=1

Function
REQ-006 Forwarding SHALL never be applied to source address 0.
REQ-007 forwardD[p] SHALL be 1 iff src != 0, src == WAM, wregM=1 and memrdM=0.
REQ-008 forwardE[p] SHALL select with priority: MDU (mdu_wb and src == mdu_dst), then M (wregM, memrdM=0), then W (wregW), then 00.
REQ-009 Load-use hazard (ld_haz) SHALL assert when memrdE=1, wregE=1, WAE != 0, and WAE equals any srcD port.
REQ-010 Branch hazard (br_haz) SHALL assert when useD[p]=1 and srcD[p] != 0 and either (srcD[p] == WAE and wregE) or (srcD[p] == WAM and memrdM).
REQ-011 Scoreboard hazard (sb_haz) SHALL assert when pending=1, mdu_dst != 0, mdu_wb=0, and any srcD port equals mdu_dst.
REQ-012 Data stall (dstall = ld_haz | br_haz | sb_haz) SHALL drive stallF=stallD=1 and flushE=1.
REQ-013 Structural stall (sstall) SHALL assert when mdu_startE=1 and the MDU state is BUSY.
REQ-014 sstall SHALL drive stallF=stallD=stallE=1 and flushM=1, and SHALL override dstall, forcing flushE=0.
REQ-015 The MDU tracker SHALL implement states IDLE, BUSY and DONE, with a counter cnt (LAT_W bits) and registered mdu_dst and pending.
REQ-016 In IDLE with mdu_startE: the tracker SHALL load cnt = max(mdu_latE, 1), capture mdu_dst, set pending=1, and move to BUSY.
REQ-017 In BUSY: cnt SHALL decrement each cycle; when cnt==1 the tracker SHALL move to DONE.
REQ-018 In DONE: mdu_wb SHALL be 1 for exactly that cycle and pending SHALL clear.
REQ-019 On leaving DONE: the next state SHALL be BUSY if mdu_startE=1 that cycle (new op accepted, no stall), otherwise IDLE.
REQ-020 An MDU op of latency L accepted in cycle t SHALL produce mdu_wb in cycle t+L+1.
REQ-021 mdu_startE while BUSY SHALL NOT be accepted; it SHALL be held by sstall until the state is DONE.
REQ-022 stall_cnt SHALL increment each cycle with stallD=1, saturate at all-ones, and clear when clr_cnt=1 (clr_cnt wins over increment).
REQ-023 All hazard and forward outputs SHALL be combinational from inputs and registered state; the only registers SHALL be the state, cnt, mdu_dst, pending and stall_cnt.

Reset
REQ-024 With resetn=0 at a rising edge: state SHALL become IDLE, with cnt=0, pending=0, mdu_dst=0, stall_cnt=0.
REQ-025 Reset SHALL take effect mid-operation; an in-flight MDU op SHALL be dropped with no mdu_wb.
REQ-026 After reset: mdu_busy=0, mdu_wb=0, and all stall and flush outputs SHALL depend only on the current combinational inputs.

Verification
REQ-027 Priority test: srcE0=5, WAM=5, wregM=1, WAW=5, wregW=1 -> forwardE[1:0]=01; set wregM=0 -> 10; set srcE0=0 -> 00.
REQ-028 Load-use test: memrdE=1, wregE=1, WAE=8, srcD1=8 -> stallF=stallD=flushE=1 for 1 cycle; stall_cnt goes 0 -> 1.
REQ-029 MDU latency test: mdu_startE, mdu_latE=3, mdu_dstE=9 at t0 -> mdu_busy from t0+1, mdu_wb at t0+4.
REQ-030 MDU scoreboard test: in the same run, srcD0=9 -> stallD=1 for t0+1..t0+3; at t0+4 forwardE=11 if srcE0=9.
REQ-031 Back-to-back MDU test: second mdu_startE at t0+2 -> stallE=1 and flushM=1 at t0+2..t0+3; accepted at t0+4 with no stall that cycle.
REQ-032 Reset and saturation test: resetn=0 at t0+2 -> no mdu_wb and mdu_busy=0 next cycle; separately, with CNT_W=3 and 10 stall cycles -> stall_cnt=7, then clr_cnt -> 0.
